csa_modaddsub_pipe: RTL

CSA_MODADDSUB_PIPE -- requirements
Module: csa_modaddsub_pipe

---
 rtl/csa_modaddsub_pipe.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csa_modaddsub_pipe.sv
// Two-stage pipelined modular add/subtract on carry-save operands.
// Result stays in carry-save form; (c_o + s_o) mod P equals (A +/- B) mod P.
module csa_modaddsub_pipe #(
  parameter int          W     = 89,
  parameter logic [W-1:0] P    = 89'h19f393cffffffffffffffff,
  parameter int          TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [W-1:0]     a_c_i,
  input  logic [W-1:0]     a_s_i,
  input  logic [W-1:0]     b_c_i,
  input  logic [W-1:0]     b_s_i,
  input  logic             op_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [W-1:0]     c_o,
  output logic [W-1:0]     s_o,
  output logic [TAG_W-1:0] tag_o
);

  // Reduces (m * 2^(W-1) [+ 2 - 2^(W+1) when sub]) modulo P at elaboration.
  // 4P >= 2^(W+1) keeps the subtract case non-negative; the value stays
  // below 16P, so a bounded repeated subtraction suffices.
  function automatic logic [W-1:0] corr_calc(input logic sub, input int m);
    logic [W+3:0] v;
    logic [W+3:0] pw;
    pw = {4'b0000, P};
    v  = (W+4)'(m) << (W-1);
    if (sub) v = v + (W+4)'(2) + (pw << 2) - ((W+4)'(1) << (W+1));
    for (int i = 0; i < 32; i++) begin
      if (v >= pw) v = v - pw;
    end
    return v[W-1:0];
  endfunction

  logic [W-1:0] corr_add [8];
  logic [W-1:0] corr_sub [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_corr
    localparam logic [W-1:0] CORR_ADD = corr_calc(1'b0, gi);
    localparam logic [W-1:0] CORR_SUB = corr_calc(1'b1, gi);
    assign corr_add[gi] = CORR_ADD;
    assign corr_sub[gi] = CORR_SUB;
  end

  logic             vld_p1_q, vld_p1_d;
  logic [W:0]       cv_p1_q, cv_p1_d;
  logic [W:0]       sv_p1_q, sv_p1_d;
  logic             op_p1_q, op_p1_d;
  logic [TAG_W-1:0] tag_p1_q, tag_p1_d;

  logic             vld_p2_q, vld_p2_d;
  logic [W-1:0]     c_p2_q, c_p2_d;
  logic [W-1:0]     s_p2_q, s_p2_d;
  logic [TAG_W-1:0] tag_p2_q, tag_p2_d;

  logic ld_p1, ld_p2, accept, adv_p2;

  // Flow control: a stage may load when empty or when its successor moves.
  always_comb begin
    ld_p2      = !vld_p2_q || out_ready_i;
    ld_p1      = !vld_p1_q || ld_p2;
    in_ready_o = ld_p1;
    accept     = in_valid_i && ld_p1;
    adv_p2     = ld_p2 && vld_p1_q;
    vld_p1_d   = ld_p1 ? in_valid_i : vld_p1_q;
    vld_p2_d   = ld_p2 ? vld_p1_q : vld_p2_q;
  end

  // Stage 1: conditional inversion of B and two full-adder rows.
  logic [W-1:0] bc_x, bs_x, r1_s, r1_c, r2_c;
  logic [W:0]   r2_x, r2_y, r2_z;

  always_comb begin
    bc_x = op_i ? ~b_c_i : b_c_i;
    bs_x = op_i ? ~b_s_i : b_s_i;
    r1_s = a_c_i ^ a_s_i ^ bc_x;
    r1_c = (a_c_i & a_s_i) | (a_c_i & bc_x) | (a_s_i & bc_x);
    r2_x = {1'b0, r1_s};
    r2_y = {r1_c, 1'b0};
    r2_z = {1'b0, bs_x};
    r2_c = (r2_x[W-1:0] & r2_y[W-1:0]) | (r2_x[W-1:0] & r2_z[W-1:0]) |
           (r2_y[W-1:0] & r2_z[W-1:0]);
    cv_p1_d  = accept ? {r2_c, 1'b0} : cv_p1_q;
    sv_p1_d  = accept ? (r2_x ^ r2_y ^ r2_z) : sv_p1_q;
    op_p1_d  = accept ? op_i : op_p1_q;
    tag_p1_d = accept ? tag_i : tag_p1_q;
  end

  // Stage 2: fold the top two columns into M, add the mod-P correction.
  logic         hs, hc, fs, fc;
  logic [2:0]   m;
  logic [W-1:0] corr, lx, ly;
  logic [W-2:0] mj;

  always_comb begin
    hs   = cv_p1_q[W-1] ^ sv_p1_q[W-1];
    hc   = cv_p1_q[W-1] & sv_p1_q[W-1];
    fs   = cv_p1_q[W] ^ sv_p1_q[W] ^ hc;
    fc   = (cv_p1_q[W] & sv_p1_q[W]) | (cv_p1_q[W] & hc) | (sv_p1_q[W] & hc);
    m    = {fc, fs, hs};
    corr = op_p1_q ? corr_sub[m] : corr_add[m];
    lx   = {1'b0, cv_p1_q[W-2:0]};
    ly   = {1'b0, sv_p1_q[W-2:0]};
    // Top bit of lx/ly is zero, so the carry out of column W-1 is always 0.
    mj   = (lx[W-2:0] & ly[W-2:0]) | (lx[W-2:0] & corr[W-2:0]) |
           (ly[W-2:0] & corr[W-2:0]);
    c_p2_d   = adv_p2 ? {mj, 1'b0} : c_p2_q;
    s_p2_d   = adv_p2 ? (lx ^ ly ^ corr) : s_p2_q;
    tag_p2_d = adv_p2 ? tag_p1_q : tag_p2_q;
  end

  // Stage boundary registers: control and outputs are reset, internals are not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      c_p2_q   <= '0;
      s_p2_q   <= '0;
      tag_p2_q <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      c_p2_q   <= c_p2_d;
      s_p2_q   <= s_p2_d;
      tag_p2_q <= tag_p2_d;
    end
  end

  always_ff @(posedge clk) begin
    cv_p1_q  <= cv_p1_d;
    sv_p1_q  <= sv_p1_d;
    op_p1_q  <= op_p1_d;
    tag_p1_q <= tag_p1_d;
  end

  assign out_valid_o = vld_p2_q;
  assign c_o         = c_p2_q;
  assign s_o         = s_p2_q;
  assign tag_o       = tag_p2_q;

endmodule
